if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register in the 16-bit RISC core.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache, with miss refill over a simple request/ready memory port.
- Each cycle it presents fetch address, instruction and a hit/valid strobe, which the IF/ID register samples on the following negedge.
- Handles stall and branch redirect.

---
 rtl/if_fetch_unit.sv | 111 +++++++++++
 tb/tb_if_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, direct-mapped one-word-per-line I-cache and miss refill FSM.
// Outputs are registered and sampled by the IF/ID register on the following negedge.
module if_fetch_unit #(
    parameter int unsigned INDEX_W   = 3,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [15:0] branch_target_in,
    input  logic        flush_in,
    output logic        mem_req_out,
    output logic [15:0] mem_addr_out,
    input  logic        mem_ready_in,
    input  logic [15:0] mem_data_in,
    output logic [15:0] addr_out,
    output logic [15:0] instr_out,
    output logic        hit_fetch_out
);
    localparam int unsigned LINES = 2 ** INDEX_W;
    localparam int unsigned TAG_W = 16 - INDEX_W;

    typedef enum logic [0:0] {StLookup, StMiss} state_e;

    state_e             state_q;
    logic [15:0]        pc_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [15:0]        data_mem [LINES];
    logic               redirect_pending_q;
    logic [15:0]        redirect_target_q;

    logic [INDEX_W-1:0] pc_index;
    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               lookup_hit;

    assign pc_index   = pc_q[INDEX_W-1:0];
    assign pc_tag     = pc_q[15:INDEX_W];
    // The refill line is addressed by the held request address, not the (possibly redirected) PC.
    assign fill_index = mem_addr_out[INDEX_W-1:0];
    assign fill_tag   = mem_addr_out[15:INDEX_W];
    assign lookup_hit = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StLookup;
            pc_q               <= RESET_PC;
            valid_q            <= '0;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= '0;
            addr_out           <= '0;
            instr_out          <= '0;
            hit_fetch_out      <= 1'b0;
            mem_req_out        <= 1'b0;
            mem_addr_out       <= '0;
        end else begin
            case (state_q)
                StLookup: begin
                    if (branch_taken_in) begin
                        addr_out      <= pc_q;
                        instr_out     <= NOP_INSTR;
                        hit_fetch_out <= 1'b1;
                        pc_q          <= branch_target_in;
                    end else if (stall_in) begin
                        hit_fetch_out <= 1'b0;
                    end else if (lookup_hit) begin
                        addr_out      <= pc_q;
                        instr_out     <= data_mem[pc_index];
                        hit_fetch_out <= 1'b1;
                        pc_q          <= pc_q + 16'd1;
                    end else begin
                        hit_fetch_out <= 1'b0;
                        mem_req_out   <= 1'b1;
                        mem_addr_out  <= pc_q;
                        state_q       <= StMiss;
                    end
                end
                StMiss: begin
                    hit_fetch_out <= 1'b0;
                    if (mem_ready_in) begin
                        valid_q[fill_index]  <= 1'b1;
                        tag_mem[fill_index]  <= fill_tag;
                        data_mem[fill_index] <= mem_data_in;
                        mem_req_out          <= 1'b0;
                        state_q              <= StLookup;
                        redirect_pending_q   <= 1'b0;
                        if (branch_taken_in) begin
                            pc_q <= branch_target_in;
                        end else if (redirect_pending_q) begin
                            pc_q <= redirect_target_q;
                        end
                    end else if (branch_taken_in) begin
                        // Latest branch wins; applied once the refill lands.
                        redirect_pending_q <= 1'b1;
                        redirect_target_q  <= branch_target_in;
                    end
                end
                default: state_q <= StLookup;
            endcase
            // Applied last so a coincident refill write is left invalid.
            if (flush_in) begin
                valid_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan scenarios, then randomized traffic
// against a transaction-level model that tracks cached addresses per line.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        branch_taken_in = 1'b0;
    logic [15:0] branch_target_in = 16'h0000;
    logic        flush_in = 1'b0;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ready_in = 1'b0;
    logic [15:0] mem_data_in = 16'h0000;
    logic [15:0] addr_out;
    logic [15:0] instr_out;
    logic        hit_fetch_out;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .flush_in         (flush_in),
        .mem_req_out      (mem_req_out),
        .mem_addr_out     (mem_addr_out),
        .mem_ready_in     (mem_ready_in),
        .mem_data_in      (mem_data_in),
        .addr_out         (addr_out),
        .instr_out        (instr_out),
        .hit_fetch_out    (hit_fetch_out)
    );

    int total = 0;
    int bad = 0;
    int lat = 1;
    int wait_cnt = 0;
    bit rand_lat = 1'b0;

    // Model: each line remembers the full word address it holds (-1 = empty).
    logic [15:0] m_pc, m_addr, m_instr, m_maddr, m_ptgt;
    logic        m_hit, m_req, m_miss, m_pend;
    int          line_addr [8];
    logic [15:0] line_data [8];

    logic        saw_req;
    logic [15:0] saw_req_addr;
    logic        saw_hit5;
    logic        ok;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h03B1) ^ 16'h1234;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int idx;
        if (rst) begin
            m_pc = 16'h0000; m_miss = 1'b0; m_pend = 1'b0; m_ptgt = 16'h0000;
            m_addr = 16'h0000; m_instr = 16'h0000; m_hit = 1'b0;
            m_req = 1'b0; m_maddr = 16'h0000;
            foreach (line_addr[i]) line_addr[i] = -1;
            return;
        end
        if (!m_miss) begin
            idx = int'(m_pc % 16'd8);
            if (branch_taken_in) begin
                m_addr = m_pc; m_instr = 16'h0000; m_hit = 1'b1; m_pc = branch_target_in;
            end else if (stall_in) begin
                m_hit = 1'b0;
            end else if (line_addr[idx] == int'(m_pc)) begin
                m_addr = m_pc; m_instr = line_data[idx]; m_hit = 1'b1; m_pc = m_pc + 16'd1;
            end else begin
                m_hit = 1'b0; m_req = 1'b1; m_maddr = m_pc; m_miss = 1'b1;
            end
        end else begin
            m_hit = 1'b0;
            if (mem_ready_in) begin
                idx = int'(m_maddr % 16'd8);
                line_addr[idx] = int'(m_maddr);
                line_data[idx] = mem_data_in;
                m_req = 1'b0; m_miss = 1'b0;
                if (branch_taken_in) m_pc = branch_target_in;
                else if (m_pend) m_pc = m_ptgt;
                m_pend = 1'b0;
            end else if (branch_taken_in) begin
                m_pend = 1'b1; m_ptgt = branch_target_in;
            end
        end
        if (flush_in) foreach (line_addr[i]) line_addr[i] = -1;
    endtask

    // One clock: memory responder, edge, model update, then compare away from the edge.
    task automatic step();
        if (rst) begin
            wait_cnt = 0; mem_ready_in = 1'b0;
        end else if (mem_req_out === 1'b1) begin
            if (wait_cnt == 0 && rand_lat) lat = int'($urandom_range(1, 3));
            wait_cnt++;
            mem_ready_in = (wait_cnt >= lat);
        end else begin
            wait_cnt = 0; mem_ready_in = 1'b0;
        end
        mem_data_in = mem_word(mem_addr_out);
        @(posedge clk);
        model_step();
        #1;
        check("hit_fetch", {15'd0, hit_fetch_out}, {15'd0, m_hit});
        check("addr", addr_out, m_addr);
        check("instr", instr_out, m_instr);
        check("mem_req", {15'd0, mem_req_out}, {15'd0, m_req});
        check("mem_addr", mem_addr_out, m_maddr);
        if (mem_req_out === 1'b1) begin
            saw_req = 1'b1; saw_req_addr = mem_addr_out;
        end
        if (hit_fetch_out === 1'b1 && addr_out == 16'h0005) saw_hit5 = 1'b1;
    endtask

    task automatic run_until_hit(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (hit_fetch_out === 1'b1) found = 1'b1;
        end
    endtask

    task automatic redirect(input logic [15:0] tgt);
        for (int i = 0; i < 12 && m_miss; i++) step();
        branch_taken_in = 1'b1; branch_target_in = tgt;
        step();
        branch_taken_in = 1'b0;
    endtask

    initial begin
        saw_req = 1'b0; saw_req_addr = 16'h0000; saw_hit5 = 1'b0;

        // Reset state
        step(); step();
        check("rst_hit", {15'd0, hit_fetch_out}, 16'd0);
        check("rst_req", {15'd0, mem_req_out}, 16'd0);
        check("rst_addr", addr_out, 16'h0000);
        rst = 1'b0;

        // Cold start, memory answers 2 cycles after request
        lat = 2;
        step();
        check("cold_req", {15'd0, mem_req_out}, 16'd1);
        check("cold_mem_addr", mem_addr_out, 16'h0000);
        run_until_hit(8, ok);
        check("cold_timeout", {15'd0, ok}, 16'd1);
        check("cold_addr", addr_out, 16'h0000);
        check("cold_instr", instr_out, 16'h1234);
        step();
        check("cold_next_req_addr", mem_addr_out, 16'h0001);

        // Preload lines 0..7, then 8 back-to-back hits
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (hit_fetch_out === 1'b1 && addr_out == 16'h0007) ok = 1'b1;
        end
        check("preload_timeout", {15'd0, ok}, 16'd1);
        redirect(16'h0000);
        for (int i = 0; i < 8; i++) begin
            step();
            check("seq_hit", {15'd0, hit_fetch_out}, 16'd1);
            check("seq_addr", addr_out, 16'(i));
        end

        // Stall for 3 cycles during hits
        redirect(16'h0000);
        step(); step();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hit", {15'd0, hit_fetch_out}, 16'd0);
        end
        stall_in = 1'b0;
        step();
        check("stall_resume_hit", {15'd0, hit_fetch_out}, 16'd1);
        check("stall_resume_addr", addr_out, 16'h0002);

        // Branch to 0040 during a hit
        lat = 2;
        branch_taken_in = 1'b1; branch_target_in = 16'h0040;
        step();
        branch_taken_in = 1'b0;
        check("br_bubble_hit", {15'd0, hit_fetch_out}, 16'd1);
        check("br_bubble_instr", instr_out, 16'h0000);
        check("br_bubble_addr", addr_out, 16'h0003);
        run_until_hit(12, ok);
        check("br_timeout", {15'd0, ok}, 16'd1);
        check("br_target_addr", addr_out, 16'h0040);
        check("br_refill_addr", saw_req_addr, 16'h0040);

        // Branch to 0080 while a miss on 0005 is outstanding (flush first so 0005 misses)
        lat = 4;
        flush_in = 1'b1; branch_taken_in = 1'b1; branch_target_in = 16'h0005;
        step();
        flush_in = 1'b0; branch_taken_in = 1'b0;
        step();
        check("miss5_req_addr", mem_addr_out, 16'h0005);
        saw_hit5 = 1'b0;
        step();
        branch_taken_in = 1'b1; branch_target_in = 16'h0080;
        step();
        branch_taken_in = 1'b0;
        run_until_hit(20, ok);
        check("pend_timeout", {15'd0, ok}, 16'd1);
        check("pend_addr", addr_out, 16'h0080);
        check("pend_refill_addr", saw_req_addr, 16'h0080);
        check("pend_no_0005", {15'd0, saw_hit5}, 16'd0);
        redirect(16'h0005);
        step();
        check("line5_hit", {15'd0, hit_fetch_out}, 16'd1);
        check("line5_addr", addr_out, 16'h0005);
        check("line5_no_req", {15'd0, mem_req_out}, 16'd0);

        // PC wrap at FFFF
        lat = 1;
        redirect(16'hFFFF);
        run_until_hit(10, ok);
        check("wrap_addr_ffff", addr_out, 16'hFFFF);
        run_until_hit(10, ok);
        check("wrap_addr_0000", addr_out, 16'h0000);

        // Flush: same-cycle lookup uses pre-flush state, re-fetch then misses
        redirect(16'h0000);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("flush_same_hit", {15'd0, hit_fetch_out}, 16'd1);
        check("flush_same_addr", addr_out, 16'h0000);
        redirect(16'h0000);
        step();
        check("flush_refetch_req", {15'd0, mem_req_out}, 16'd1);
        check("flush_refetch_addr", mem_addr_out, 16'h0000);

        // Reset mid-MISS
        lat = 5;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_miss_req", {15'd0, mem_req_out}, 16'd0);
        step();
        check("rst_miss_restart", mem_addr_out, 16'h0000);

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            stall_in = ($urandom_range(0, 3) == 0);
            branch_taken_in = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)
                branch_target_in = 16'hFFF8 + 16'($urandom_range(0, 7));
            else
                branch_target_in = 16'($urandom_range(0, 31));
            flush_in = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0; flush_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
